// File: rtl/lzd_share_arbiter.sv
// lzd_share_arbiter
//   Shares one decomposable leading-zero detector (1 full, 2 half or 4 quarter
//   slices) among N_REQ posit-decode requesters. Each cycle compatible
//   requests are packed into free slices of a registered word. The detector
//   scans that word, and each requester's result is returned two edges after
//   its grant.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   req_valid     [N_REQ]          request pending per requester
//   req_size      [N_REQ*2]        0 quarter, 1 half, 2/3 full
//   req_data      [N_REQ*MAX_BITS] right-aligned operand
//   req_ready     [N_REQ]          grant (transfer on valid & ready)
//   rsp_valid     [N_REQ]          one-cycle result strobe
//   rsp_pos       [N_REQ*POS_W]    index of most-significant 0 bit
//   rsp_all_ones  [N_REQ]          operand had no 0 bit (rsp_pos = 0)
module lzd_share_arbiter #(
  parameter int MAX_BITS = 32,
  parameter int N_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [2*N_REQ-1:0]               req_size,
  input  logic [N_REQ*MAX_BITS-1:0]        req_data,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [N_REQ*$clog2(MAX_BITS)-1:0] rsp_pos,
  output logic [N_REQ-1:0]                 rsp_all_ones
);

  localparam int Q_BITS = MAX_BITS / 4;
  localparam int H_BITS = MAX_BITS / 2;
  localparam int POS_W  = $clog2(MAX_BITS);
  localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] SZ_QUARTER = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_FULL    = 2'd2;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             all_ones;
  } lzd_t;

  // Most-significant 0 bit among the low w bits of v.
  function automatic lzd_t scan(input logic [MAX_BITS-1:0] v, input int w);
    lzd_t r;
    r.pos      = '0;
    r.all_ones = 1'b1;
    for (int b = 0; b < MAX_BITS; b++) begin
      if (b < w && !v[b]) begin
        r.pos      = POS_W'(b);
        r.all_ones = 1'b0;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request normalisation: size 3 is folded onto full.
  // ---------------------------------------------------------------------------
  logic [1:0] size_norm [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_size
    assign size_norm[gi] = (req_size[2*gi +: 2] == 2'd3) ? SZ_FULL : req_size[2*gi +: 2];
  end

  // ---------------------------------------------------------------------------
  // Packing: round-robin scan from rr, tracking quarter occupancy.
  // slot_next holds the half index for half requests, quarter index for quarters.
  // ---------------------------------------------------------------------------
  logic [RR_W-1:0]  rr_reg;
  logic [RR_W-1:0]  rr_next;
  logic [N_REQ-1:0] grant;
  logic [1:0]       slot_next [N_REQ];

  always_comb begin
    logic [3:0] occ;
    logic       head_found;
    int         idx;
    int         q;
    grant      = '0;
    rr_next    = rr_reg;
    occ        = '0;
    head_found = 1'b0;
    idx        = 0;
    q          = 0;
    for (int i = 0; i < N_REQ; i++) slot_next[i] = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx] && !rst) begin
        case (size_norm[idx])
          SZ_FULL: begin
            // Full width only ever rides alone, as the head.
            if (!head_found) begin
              grant[idx] = 1'b1;
              occ        = 4'hF;
            end
          end
          SZ_HALF: begin
            if (occ[3:2] == 2'b00) begin
              grant[idx]     = 1'b1;
              slot_next[idx] = 2'd1;
              occ[3:2]       = 2'b11;
            end else if (occ[1:0] == 2'b00) begin
              grant[idx]     = 1'b1;
              slot_next[idx] = 2'd0;
              occ[1:0]       = 2'b11;
            end
          end
          default: begin
            // Prefer filling a half that already holds one quarter (lowest
            // free quarter wins), so whole halves stay available for halves.
            q = -1;
            for (int j = 3; j >= 0; j--) begin
              if (!occ[j] && occ[j ^ 1]) q = j;
            end
            if (q < 0) begin
              if (occ[3:2] == 2'b00)      q = 3;
              else if (occ[1:0] == 2'b00) q = 1;
            end
            if (q >= 0) begin
              grant[idx]     = 1'b1;
              slot_next[idx] = 2'(q);
              occ[q]         = 1'b1;
            end
          end
        endcase
        if (!head_found) begin
          head_found = 1'b1;
          rr_next    = (idx == N_REQ - 1) ? '0 : RR_W'(idx + 1);
        end
      end
    end
  end

  assign req_ready = grant;

  // Packed word: granted operands in their slots, unused slots all ones so
  // they never produce a spurious zero.
  logic [MAX_BITS-1:0] packed_next;

  always_comb begin
    packed_next = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        case (size_norm[i])
          SZ_FULL:
            packed_next = req_data[i*MAX_BITS +: MAX_BITS];
          SZ_HALF:
            packed_next[int'(slot_next[i])*H_BITS +: H_BITS] = req_data[i*MAX_BITS +: H_BITS];
          default:
            packed_next[int'(slot_next[i])*Q_BITS +: Q_BITS] = req_data[i*MAX_BITS +: Q_BITS];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic [MAX_BITS-1:0] s1_word_reg;
  logic [N_REQ-1:0]    s1_valid_reg;
  logic [1:0]          s1_slot_reg [N_REQ];
  logic [1:0]          s1_size_reg [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg       <= '0;
      s1_valid_reg <= '0;
    end else begin
      rr_reg       <= rr_next;
      s1_valid_reg <= grant;
    end
  end

  always_ff @(posedge clk) begin
    s1_word_reg <= packed_next;
    for (int i = 0; i < N_REQ; i++) begin
      s1_slot_reg[i] <= slot_next[i];
      s1_size_reg[i] <= size_norm[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Shared decomposable detector on the stage-1 word
  // ---------------------------------------------------------------------------
  lzd_t full_res;
  lzd_t half_res    [2];
  lzd_t quarter_res [4];

  assign full_res = scan(s1_word_reg, MAX_BITS);

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_res[gi] = scan(MAX_BITS'(s1_word_reg[gi*H_BITS +: H_BITS]), H_BITS);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_quarter
    assign quarter_res[gi] = scan(MAX_BITS'(s1_word_reg[gi*Q_BITS +: Q_BITS]), Q_BITS);
  end

  lzd_t sel_res [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      case (s1_size_reg[i])
        SZ_FULL: sel_res[i] = full_res;
        SZ_HALF: sel_res[i] = half_res[s1_slot_reg[i][0]];
        default: sel_res[i] = quarter_res[s1_slot_reg[i]];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= '0;
      rsp_pos      <= '0;
      rsp_all_ones <= '0;
    end else begin
      rsp_valid <= s1_valid_reg;
      for (int i = 0; i < N_REQ; i++) begin
        if (s1_valid_reg[i]) begin
          rsp_pos[i*POS_W +: POS_W] <= sel_res[i].pos;
          rsp_all_ones[i]           <= sel_res[i].all_ones;
        end
      end
    end
  end

endmodule

// File: doc/lzd_share_arbiter.md
Name: lzd_share_arbiter

Overview:
- Shares one decomposable leading-zero-detect datapath (full / 2×half / 4×quarter slices) among N_REQ posit-decode requesters.
- Each requester asks for a regime scan of a quarter-, half- or full-width operand.
- Each cycle the arbiter packs compatible requests into the slices, drives the shared detector from a registered packed word, and returns per-requester results two cycles after acceptance.

Parameters:
- MAX_BITS, 32: full operand width; must be a multiple of 4 and ≥ 8.
- N_REQ, 4: number of requesters; fixed ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request pending per requester.
- req_size  in  N_REQ×2  per requester: 0 = quarter, 1 = half, 2 = full, 3 = treated as full.
- req_data  in  N_REQ×MAX_BITS  operand, right-aligned; bits above the size are ignored.
- req_ready  out  N_REQ  grant; the transfer occurs when valid & ready at a clock edge.
- rsp_valid  out  N_REQ  one-cycle result strobe per requester.
- rsp_pos  out  N_REQ×$clog2(MAX_BITS)  index (LSB = 0) of the most-significant 0 bit within the operand. Half and quarter results are zero-extended.
- rsp_all_ones  out  N_REQ  operand contained no 0 bit; rsp_pos = 0 in that case.

Behaviour:
- Slots: Q3..Q0 are the quarters of the packed word (Q3 = MSBs). H1 = Q3:Q2, H0 = Q1:Q0. FULL occupies all four.
- Packing, combinational on req_valid/req_size and round-robin pointer rr:
  - Scan requesters in order rr, rr+1, … (mod N_REQ).
  - The first valid requester is the head and is always granted.
  - A full request is granted only if it is the head; then nothing else is granted that cycle.
  - A half request takes H1 if H1 is wholly free, else H0 if wholly free, else it is skipped.
  - A quarter request takes the lowest-numbered free quarter inside a half that already holds a quarter, else the upper quarter of the highest wholly free half, else it is skipped.
- req_ready[i] = grant[i]. It depends combinationally on req_valid and req_size and is never asserted without req_valid. Requesters hold data until granted.
- rr update: on any grant, rr <= (head + 1) mod N_REQ; no grant leaves rr unchanged. Every continuously valid requester is therefore granted within N_REQ cycles, full-width requests included.
- Stage 1 registers, at the grant edge:
  - packed word: operand placed in its slot(s), unused slots filled with ones;
  - per-requester slot id and size;
  - stage-1 valid per requester.
- The shared detector is combinational on the stage-1 word. Each requester's result is selected by size/slot:
  - full: full output;
  - half: half[h] output;
  - quarter: quarter[q] output.
- Stage 2 registers rsp_pos, rsp_all_ones and rsp_valid.
- Latency: a grant at edge T gives rsp_valid high during the cycle after edge T+1, for exactly one cycle.
- Throughput: one new request per requester per cycle. There is no response backpressure; results are always consumed.
- Reset: rst clears rr, both pipeline valid stages, rsp_valid, rsp_pos and rsp_all_ones to 0. In-flight requests are dropped with no response. req_ready is 0 while rst is high.
- Illegal size 3 behaves exactly as full.

Test Plan:
1. All four requesters valid, size quarter, data 0xF0, 0xFF, 0x7F, 0x01, rr = 0 → all granted in one cycle. Two cycles later:
   - req0: pos 3, all_ones 0;
   - req1: pos 0, all_ones 1;
   - req2: pos 7, all_ones 0;
   - req3: pos 7, all_ones 0.
2. req0 full 0xFFFF_0FFF, req1 half 0x00FF, rr = 0:
   - cycle A: only req0 granted; response pos 15.
   - cycle A+1: req1 granted; response pos 15.
   - rr after cycle A+1 = 2.
3. rr = 1, req0 full, req1 half, req2 half, req3 quarter, all held valid → grant order:
   - {1, 2} (H1, H0);
   - {3};
   - {0};
   - rr back to 1.
   - No starvation within 4 cycles.
4. req0 quarter 0x80, req1 half 0xFFFE, req2 quarter 0x3F, req3 idle, rr = 0 → all three granted in one cycle: req0 → Q3, req1 → H0, req2 → Q2. Responses: pos 6, 0, 7.
5. Back-to-back: req2 full-width, valid every cycle with incrementing data → one grant and one response per cycle, each exactly 2 cycles after its grant edge, in order.
6. Assert rst for one cycle the edge after a grant → no rsp_valid for that request; rr = 0; the next grant resumes normally with 2-cycle latency.
